// File: rtl/lp5_ca_cmd_encoder.sv
// LPDDR5-style two-beat CA command encoder with registered cs/ca outputs.
// Optional macro LP5_CMD_GAP_CHECK_EN compiles in the MIN_GAP idle spacing after each command.
module lp5_ca_cmd_encoder #(
    parameter int CA_W    = 7,
    parameter int MIN_GAP = 2
) (
    input  logic            ck_t,
    input  logic            reset_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_op,
    input  logic [3:0]      cmd_ba,
    input  logic [CA_W-1:0] cmd_addr,
    output logic            cs,
    output logic [CA_W-1:0] ca,
    output logic            busy,
    output logic            cmd_err
);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_RSVD = 3'd7;

`ifdef LP5_CMD_GAP_CHECK_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [3:0] GAP_LOAD = (MIN_GAP > 0) ? 4'(MIN_GAP - 1) : 4'd0;

    logic [3:0] r_gap_cnt;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    // Without the gap feature MIN_GAP has no effect on behaviour.
    logic w_unused_gap;
    assign w_unused_gap = (MIN_GAP != 0);
`endif

    state_t          r_state;
    logic            r_cs;
    logic [CA_W-1:0] r_ca;
    logic [CA_W-1:0] r_addr;
    logic            r_busy;
    logic            r_ready;
    logic            r_err;

    assign cs        = r_cs;
    assign ca        = r_ca;
    assign busy      = r_busy;
    assign cmd_ready = r_ready;
    assign cmd_err   = r_err;

    // Outputs are computed for the next state, so the BEAT0 word appears
    // on the cycle right after acceptance; op/ba are captured into r_ca there
    // and addr is held in r_addr for BEAT1.
    always_ff @(posedge ck_t or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cs      <= 1'b0;
            r_ca      <= '0;
            r_addr    <= '0;
            r_busy    <= 1'b0;
            r_ready   <= 1'b1;
            r_err     <= 1'b0;
`ifdef LP5_CMD_GAP_CHECK_EN
            r_gap_cnt <= 4'd0;
`endif
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_op == OP_RSVD) begin
                            r_err <= 1'b1;
                        end else if (cmd_op != OP_NOP) begin
                            r_state <= BEAT0;
                            r_cs    <= 1'b1;
                            r_ca    <= CA_W'({cmd_op, cmd_ba});
                            r_addr  <= cmd_addr;
                            r_busy  <= 1'b1;
                            r_ready <= 1'b0;
                        end
                    end
                end
                BEAT0: begin
                    r_state <= BEAT1;
                    r_cs    <= 1'b0;
                    r_ca    <= r_addr;
                end
                BEAT1: begin
                    r_cs <= 1'b0;
                    r_ca <= '0;
`ifdef LP5_CMD_GAP_CHECK_EN
                    if (MIN_GAP == 0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_state   <= GAP;
                        r_gap_cnt <= GAP_LOAD;
                    end
`else
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
`endif
                end
`ifdef LP5_CMD_GAP_CHECK_EN
                GAP: begin
                    r_cs <= 1'b0;
                    r_ca <= '0;
                    if (r_gap_cnt == 4'd0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                    r_cs    <= 1'b0;
                    r_ca    <= '0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lp5_ca_cmd_encoder.sv
// Self-checking bench for lp5_ca_cmd_encoder: a queue of expected per-cycle
// bus words is built from each accepted command and compared every cycle.
module tb_lp5_ca_cmd_encoder;

    localparam int CA_W    = 7;
    localparam int MIN_GAP = 2;
`ifdef LP5_CMD_GAP_CHECK_EN
    localparam int GAP_CYCLES = MIN_GAP;
`else
    localparam int GAP_CYCLES = 0;
`endif

    logic            ck_t;
    logic            reset_n;
    logic            cmdValid;
    logic            cmdReady;
    logic [2:0]      cmdOp;
    logic [3:0]      cmdBa;
    logic [CA_W-1:0] cmdAddr;
    logic            csOut;
    logic [CA_W-1:0] caOut;
    logic            busyOut;
    logic            cmdErr;

    lp5_ca_cmd_encoder #(.CA_W(CA_W), .MIN_GAP(MIN_GAP)) dut (
        .ck_t      (ck_t),
        .reset_n   (reset_n),
        .cmd_valid (cmdValid),
        .cmd_ready (cmdReady),
        .cmd_op    (cmdOp),
        .cmd_ba    (cmdBa),
        .cmd_addr  (cmdAddr),
        .cs        (csOut),
        .ca        (caOut),
        .busy      (busyOut),
        .cmd_err   (cmdErr)
    );

    initial ck_t = 1'b0;
    always #5 ck_t = ~ck_t;

    typedef struct {
        logic            cs;
        logic [CA_W-1:0] ca;
    } beat_t;

    beat_t expQ[$];
    int    csCycles[$];
    int    checks = 0;
    int    errors = 0;
    int    cycle  = 0;
    logic  errPending = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cycle);
        end
    endtask

    // One cycle: check the current cycle against the model, then drive the
    // inputs seen by the next rising edge and update the model accordingly.
    task automatic applyStimulus(input logic valid, input logic [2:0] op,
                                 input logic [3:0] ba, input logic [CA_W-1:0] addr);
        beat_t exp;
        beat_t b;
        logic  idleNow;
        @(negedge ck_t);
        cycle++;
        idleNow = (expQ.size() == 0);
        if (idleNow) begin
            exp.cs = 1'b0;
            exp.ca = '0;
        end else begin
            exp = expQ.pop_front();
        end
        checkOutput("cs", {31'd0, csOut}, {31'd0, exp.cs});
        checkOutput("ca", 32'(caOut), 32'(exp.ca));
        checkOutput("busy", {31'd0, busyOut}, {31'd0, !idleNow});
        checkOutput("cmd_ready", {31'd0, cmdReady}, {31'd0, idleNow});
        checkOutput("cmd_err", {31'd0, cmdErr}, {31'd0, errPending});
        if (csOut === 1'b1) csCycles.push_back(cycle);

        cmdValid = valid;
        cmdOp    = op;
        cmdBa    = ba;
        cmdAddr  = addr;
        errPending = 1'b0;
        if (valid && idleNow) begin
            if (op == 3'd7) begin
                errPending = 1'b1;
            end else if (op != 3'd0) begin
                b.cs = 1'b1;
                b.ca = CA_W'(int'(op) * 16 + int'(ba));
                expQ.push_back(b);
                b.cs = 1'b0;
                b.ca = addr;
                expQ.push_back(b);
                b.ca = '0;
                for (int g = 0; g < GAP_CYCLES; g++) expQ.push_back(b);
            end
        end
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 3'd0, 4'd0, '0);
    endtask

    initial begin
        int c0;
        reset_n  = 1'b0;
        cmdValid = 1'b0;
        cmdOp    = 3'd0;
        cmdBa    = 4'd0;
        cmdAddr  = '0;
        #12;
        checkOutput("reset_cs", {31'd0, csOut}, 32'd0);
        checkOutput("reset_ca", 32'(caOut), 32'd0);
        checkOutput("reset_busy", {31'd0, busyOut}, 32'd0);
        checkOutput("reset_err", {31'd0, cmdErr}, 32'd0);
        checkOutput("reset_ready", {31'd0, cmdReady}, 32'd1);
        @(negedge ck_t);
        #1 reset_n = 1'b1;

        $display("[TB] directed: ACT ba=3 addr=55");
        applyStimulus(1'b1, 3'd1, 4'h3, 7'h55);
        idleCycles(5);

        $display("[TB] directed: back-to-back RD with held valid");
        csCycles.delete();
        c0 = cycle + 1;
        for (int k = 0; k < 9; k++) applyStimulus(1'b1, 3'd3, 4'h2, 7'h11);
        idleCycles(6);
        checkOutput("rd_second_beat0", (csCycles.size() >= 2) ? 32'(csCycles[1] - c0) : 32'hFFFF,
                    32'(4 + GAP_CYCLES));

        $display("[TB] directed: reserved op and NOP");
        applyStimulus(1'b1, 3'd7, 4'h5, 7'h22);
        applyStimulus(1'b0, 3'd7, 4'h5, 7'h22);
        applyStimulus(1'b1, 3'd0, 4'h1, 7'h01);
        applyStimulus(1'b1, 3'd2, 4'h9, 7'h3C);
        idleCycles(6);

        $display("[TB] directed: reset during BEAT0 of WR");
        applyStimulus(1'b1, 3'd4, 4'hA, 7'h6B);
        applyStimulus(1'b0, 3'd0, 4'h0, 7'h00);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("abort_cs", {31'd0, csOut}, 32'd0);
        checkOutput("abort_ca", 32'(caOut), 32'd0);
        checkOutput("abort_busy", {31'd0, busyOut}, 32'd0);
        checkOutput("abort_ready", {31'd0, cmdReady}, 32'd1);
        expQ.delete();
        errPending = 1'b0;
        @(negedge ck_t);
        #1 reset_n = 1'b1;
        idleCycles(4);

        $display("[TB] random stimulus");
        for (int k = 0; k < 400; k++) begin
            applyStimulus(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                          4'($urandom_range(0, 15)), CA_W'($urandom));
        end
        idleCycles(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
